// File: rtl/data_path_pkg.sv
// Shared widths, IR field positions and CON condition codes
// for the single-bus CPU datapath.
package data_path_pkg;

    localparam int BUS_W = 32;
    localparam int REG_N = 16;
    localparam int IDX_W = 4;
    localparam int MEM_D = 512;
    localparam int MAR_W = 9;

    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;
    localparam int C_HI = 18;
    localparam int CON_HI = 20;
    localparam int CON_LO = 19;
    localparam int OP_LO = 27;

    typedef enum logic [1:0] {
        CON_EQ = 2'b00,
        CON_NE = 2'b01,
        CON_GE = 2'b10,
        CON_LT = 2'b11
    } con_t;

    function automatic logic con_met(
        logic [1:0] code,
        logic [BUS_W-1:0] v
    );
        logic m;
        m = 1'b0;
        unique case (con_t'(code))
            CON_EQ: m = (v == '0);
            CON_NE: m = (v != '0);
            CON_GE: m = !v[BUS_W-1];
            CON_LT: m = v[BUS_W-1];
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_path_if.sv
// Control word, input device and output port bundle
// between the control unit and the datapath.
interface data_path_if;

    logic HIin, LOin, Zhighin, Zlowin, PCin;
    logic MDRin, MARin, IRin, Yin, InPortin;
    logic OutPortin, Out_Portin, Cin, CONin, Rin;

    logic HIout, LOout, Zhighout, Zlowout, PCout;
    logic MDRout, MARout, InPortout, Csignout;
    logic Rout, BAout;

    logic Gra, Grb, Grc, ADD, IncPC;
    logic MD_read, Read, Write;
    logic MAR_clear, CONFF, Strobe;

    logic [data_path_pkg::BUS_W-1:0] INPUT_UNIT;
    logic [data_path_pkg::BUS_W-1:0] OUTPUT_UNIT;

    modport master (
        output HIin, LOin, Zhighin, Zlowin, PCin,
        output MDRin, MARin, IRin, Yin, InPortin,
        output OutPortin, Out_Portin, Cin, CONin, Rin,
        output HIout, LOout, Zhighout, Zlowout, PCout,
        output MDRout, MARout, InPortout, Csignout,
        output Rout, BAout,
        output Gra, Grb, Grc, ADD, IncPC,
        output MD_read, Read, Write,
        output MAR_clear, CONFF, Strobe,
        output INPUT_UNIT,
        input OUTPUT_UNIT
    );

    modport slave (
        input HIin, LOin, Zhighin, Zlowin, PCin,
        input MDRin, MARin, IRin, Yin, InPortin,
        input OutPortin, Out_Portin, Cin, CONin, Rin,
        input HIout, LOout, Zhighout, Zlowout, PCout,
        input MDRout, MARout, InPortout, Csignout,
        input Rout, BAout,
        input Gra, Grb, Grc, ADD, IncPC,
        input MD_read, Read, Write,
        input MAR_clear, CONFF, Strobe,
        input INPUT_UNIT,
        output OUTPUT_UNIT
    );

endinterface

// File: rtl/data_path_reg32.sv
// Enable register with synchronous active-low clear; width
// defaults to a full bus word.
module reg32 #(
    parameter int W = 32
) (
    input logic clock,
    input logic clear,
    input logic en,
    input logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (!clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/data_path.sv
// Single-bus datapath: register file, ALU, MAR/MDR with local
// memory, I/O ports and the CON branch-condition flip-flop.
module data_path
    import data_path_pkg::*;
(
    input logic clock,
    input logic clear,
    data_path_if.slave io
);

    logic [BUS_W-1:0] bus, ba, csign, mem_rd, mdr_d;
    logic [BUS_W-1:0] r [REG_N];
    logic [BUS_W-1:0] hi, lo, zhigh, zlow, pc;
    logic [BUS_W-1:0] mdr, ir, y, inport, outport;
    logic [MAR_W-1:0] mar, mar_d;
    logic [IDX_W-1:0] idx;
    logic [BUS_W:0] alu;
    logic con, con_d;
    logic [BUS_W-1:0] mem [MEM_D];

    always_comb begin
        idx = '0;
        if (io.Gra) begin
            idx = ir[RA_HI:RA_LO];
        end else if (io.Grb) begin
            idx = ir[RB_HI:RB_LO];
        end else if (io.Grc) begin
            idx = ir[RC_HI:RC_LO];
        end
    end

    assign ba = (idx == '0) ? '0 : r[idx];
    assign csign = {{(BUS_W-C_HI-1){ir[C_HI]}}, ir[C_HI:0]};

    always_comb begin
        bus = '0;
        if (io.Rout) begin
            bus = r[idx];
        end else if (io.BAout) begin
            bus = ba;
        end else if (io.PCout) begin
            bus = pc;
        end else if (io.MDRout) begin
            bus = mdr;
        end else if (io.Zlowout) begin
            bus = zlow;
        end else if (io.Zhighout) begin
            bus = zhigh;
        end else if (io.HIout) begin
            bus = hi;
        end else if (io.LOout) begin
            bus = lo;
        end else if (io.MARout) begin
            bus = {{(BUS_W-MAR_W){1'b0}}, mar};
        end else if (io.InPortout) begin
            bus = inport;
        end else if (io.Csignout) begin
            bus = csign;
        end
    end

    // Bit BUS_W of the ALU result is the carry into Zhigh.
    always_comb begin
        alu = {1'b0, bus};
        if (io.IncPC) begin
            alu = {1'b0, bus} + {{BUS_W{1'b0}}, 1'b1};
        end else if (io.ADD) begin
            alu = {1'b0, y} + {1'b0, bus};
        end
    end

    for (genvar i = 0; i < REG_N; i++) begin : g_r
        reg32 u_r (
            .clock(clock),
            .clear(clear),
            .en(io.Rin && idx == IDX_W'(i)),
            .d(bus),
            .q(r[i])
        );
    end

    reg32 u_hi (
        .clock(clock), .clear(clear),
        .en(io.HIin), .d(bus), .q(hi)
    );
    reg32 u_lo (
        .clock(clock), .clear(clear),
        .en(io.LOin), .d(bus), .q(lo)
    );
    reg32 u_zhigh (
        .clock(clock), .clear(clear),
        .en(io.Zhighin),
        .d({{(BUS_W-1){1'b0}}, alu[BUS_W]}),
        .q(zhigh)
    );
    reg32 u_zlow (
        .clock(clock), .clear(clear),
        .en(io.Zlowin), .d(alu[BUS_W-1:0]), .q(zlow)
    );
    reg32 u_pc (
        .clock(clock), .clear(clear),
        .en(io.PCin), .d(bus), .q(pc)
    );
    reg32 u_ir (
        .clock(clock), .clear(clear),
        .en(io.IRin), .d(bus), .q(ir)
    );
    reg32 u_y (
        .clock(clock), .clear(clear),
        .en(io.Yin), .d(bus), .q(y)
    );

    assign mem_rd = mem[mar];
    assign mdr_d = io.MD_read ? mem_rd : bus;

    // A memory-sourced load without Read leaves MDR unchanged.
    reg32 u_mdr (
        .clock(clock), .clear(clear),
        .en(io.MDRin && (!io.MD_read || io.Read)),
        .d(mdr_d), .q(mdr)
    );

    assign mar_d = io.MAR_clear ? '0 : bus[MAR_W-1:0];

    reg32 #(.W(MAR_W)) u_mar (
        .clock(clock), .clear(clear),
        .en(io.MAR_clear || io.MARin),
        .d(mar_d), .q(mar)
    );

    always_ff @(posedge clock) begin
        if (io.Write) begin
            mem[mar] <= mdr;
        end
    end

    reg32 u_inport (
        .clock(clock), .clear(clear),
        .en(io.Strobe || io.InPortin),
        .d(io.INPUT_UNIT), .q(inport)
    );
    reg32 u_outport (
        .clock(clock), .clear(clear),
        .en(io.OutPortin || io.Out_Portin),
        .d(bus), .q(outport)
    );

    assign io.OUTPUT_UNIT = outport;

    assign con_d = io.CONFF
        ? 1'b1
        : con_met(ir[CON_HI:CON_LO], bus);

    reg32 #(.W(1)) u_con (
        .clock(clock), .clear(clear),
        .en(io.CONFF || io.CONin),
        .d(con_d), .q(con)
    );

    // CON feeds the branch logic outside this block; Cin is reserved.
    logic unused_bits;
    assign unused_bits = ^{io.Cin, ir[BUS_W-1:OP_LO], con};

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path with a cycle-level reference
// model checked every cycle plus literal end-point checks.
module tb_data_path;

    logic clock;
    logic clear;
    logic live;
    int checks;
    int errors;

    data_path_if f ();

    data_path dut (
        .clock(clock),
        .clear(clear),
        .io(f)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [31:0] m_r [16];
    logic [31:0] m_hi, m_lo, m_zh, m_zl, m_pc;
    logic [31:0] m_mdr, m_ir, m_y, m_in, m_out;
    logic [8:0] m_mar;
    logic m_con;
    logic [31:0] m_mem [int];

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic idle();
        f.HIin = 0; f.LOin = 0; f.Zhighin = 0; f.Zlowin = 0;
        f.PCin = 0; f.MDRin = 0; f.MARin = 0; f.IRin = 0;
        f.Yin = 0; f.InPortin = 0; f.OutPortin = 0;
        f.Out_Portin = 0; f.Cin = 0; f.CONin = 0; f.Rin = 0;
        f.HIout = 0; f.LOout = 0; f.Zhighout = 0; f.Zlowout = 0;
        f.PCout = 0; f.MDRout = 0; f.MARout = 0;
        f.InPortout = 0; f.Csignout = 0; f.Rout = 0; f.BAout = 0;
        f.Gra = 0; f.Grb = 0; f.Grc = 0; f.ADD = 0; f.IncPC = 0;
        f.MD_read = 0; f.Read = 0; f.Write = 0;
        f.MAR_clear = 0; f.CONFF = 0; f.Strobe = 0;
    endtask

    // One clock: apply the datapath rules to the model at the edge.
    task automatic tick();
        logic [3:0] ix;
        logic [31:0] b, rd;
        logic [32:0] s;
        logic cn;
        @(posedge clock);
        ix = f.Gra ? m_ir[26:23] : f.Grb ? m_ir[22:19]
           : f.Grc ? m_ir[18:15] : 4'd0;
        if (f.Rout) b = m_r[ix];
        else if (f.BAout) b = (ix == 0) ? 32'd0 : m_r[ix];
        else if (f.PCout) b = m_pc;
        else if (f.MDRout) b = m_mdr;
        else if (f.Zlowout) b = m_zl;
        else if (f.Zhighout) b = m_zh;
        else if (f.HIout) b = m_hi;
        else if (f.LOout) b = m_lo;
        else if (f.MARout) b = 32'(m_mar);
        else if (f.InPortout) b = m_in;
        else if (f.Csignout) b = 32'($signed(m_ir[18:0]));
        else b = 32'd0;
        if (f.IncPC) s = 33'(b) + 33'd1;
        else if (f.ADD) s = 33'(m_y) + 33'(b);
        else s = 33'(b);
        rd = m_mem.exists(int'(m_mar)) ? m_mem[int'(m_mar)] : 'x;
        case (m_ir[20:19])
            2'b00: cn = (b == 0);
            2'b01: cn = (b != 0);
            2'b10: cn = ($signed(b) >= 0);
            default: cn = ($signed(b) < 0);
        endcase
        if (f.Write) m_mem[int'(m_mar)] = m_mdr;
        if (!clear) begin
            foreach (m_r[i]) m_r[i] = 0;
            m_hi = 0; m_lo = 0; m_zh = 0; m_zl = 0; m_pc = 0;
            m_mdr = 0; m_ir = 0; m_y = 0; m_in = 0; m_out = 0;
            m_mar = 0; m_con = 0;
        end else begin
            if (f.Rin) m_r[ix] = b;
            if (f.HIin) m_hi = b;
            if (f.LOin) m_lo = b;
            if (f.Zhighin) m_zh = {31'd0, s[32]};
            if (f.Zlowin) m_zl = s[31:0];
            if (f.PCin) m_pc = b;
            if (f.IRin) m_ir = b;
            if (f.Yin) m_y = b;
            if (f.MDRin && !f.MD_read) m_mdr = b;
            if (f.MDRin && f.MD_read && f.Read) m_mdr = rd;
            if (f.MAR_clear) m_mar = 0;
            else if (f.MARin) m_mar = b[8:0];
            if (f.Strobe || f.InPortin) m_in = f.INPUT_UNIT;
            if (f.OutPortin || f.Out_Portin) m_out = b;
            if (f.CONFF) m_con = 1;
            else if (f.CONin) m_con = cn;
        end
        @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (live) begin
            chk("model_out", f.OUTPUT_UNIT, m_out);
            chk("model_con", {31'd0, dut.con}, {31'd0, m_con});
        end
    end

    task automatic strobe(logic [31:0] v);
        idle();
        f.INPUT_UNIT = v;
        f.Strobe = 1;
        tick();
    endtask

    task automatic obs(string n, logic [31:0] exp);
        f.OutPortin = 1;
        tick();
        chk(n, f.OUTPUT_UNIT, exp);
    endtask

    initial begin
        live = 0;
        checks = 0;
        errors = 0;
        idle();
        f.INPUT_UNIT = 0;
        clear = 0;
        tick();
        clear = 1;
        live = 1;
        chk("reset_out", f.OUTPUT_UNIT, 32'h0);
        chk("reset_con", {31'd0, dut.con}, 32'h0);

        // Arbitrary loads, then reset on top of an active enable.
        strobe(32'h0080_0000);
        idle(); f.InPortout = 1; f.IRin = 1; tick();
        strobe(32'hDEAD_BEEF);
        idle(); f.InPortout = 1; f.PCin = 1; f.Gra = 1;
        f.Rin = 1; f.MDRin = 1; f.Zlowin = 1; tick();
        idle(); f.Gra = 1; f.Rout = 1; obs("r1_load", 32'hDEAD_BEEF);
        idle(); f.InPortout = 1; f.PCin = 1; clear = 0; tick();
        clear = 1;
        idle(); f.PCout = 1; obs("pc_clr", 32'h0);
        idle(); f.MDRout = 1; obs("mdr_clr", 32'h0);
        idle(); f.Zlowout = 1; obs("zlow_clr", 32'h0);
        idle(); f.Csignout = 1; obs("ir_clr", 32'h0);
        strobe(32'h0080_0000);
        idle(); f.InPortout = 1; f.IRin = 1; tick();
        idle(); f.Gra = 1; f.Rout = 1; obs("r1_clr", 32'h0);

        // Instruction fetch from mem[0].
        strobe(32'h0090_0055);
        idle(); f.InPortout = 1; f.MDRin = 1; tick();
        idle(); f.Write = 1; tick();
        idle(); f.PCout = 1; f.MARin = 1; f.IncPC = 1;
        f.Zlowin = 1; tick();
        idle(); f.Zlowout = 1; f.PCin = 1; f.Read = 1;
        f.MDRin = 1; f.MD_read = 1; tick();
        idle(); f.MDRout = 1; f.IRin = 1; tick();
        idle(); f.PCout = 1; obs("fetch_pc", 32'h1);
        idle(); f.MDRout = 1; obs("fetch_mdr", 32'h0090_0055);
        idle(); f.Csignout = 1; obs("fetch_ir", 32'h55);

        // Base + displacement address through Y and Z.
        strobe(32'h10);
        idle(); f.InPortout = 1; f.Grb = 1; f.Rin = 1; tick();
        idle(); f.Grb = 1; f.BAout = 1; f.Yin = 1; tick();
        idle(); f.Csignout = 1; f.ADD = 1; f.Zlowin = 1; tick();
        idle(); f.Zlowout = 1; obs("ea_zlow", 32'h65);
        idle(); f.Zlowout = 1; f.MARin = 1; tick();
        idle(); f.MARout = 1; obs("ea_mar", 32'h65);
        idle(); f.ADD = 1; f.Zlowin = 1; tick();
        idle(); f.Zlowout = 1; obs("ea_y", 32'h10);
        idle(); f.Csignout = 1; f.CONin = 1; tick();
        chk("con_ge", {31'd0, dut.con}, 32'h1);

        // R0 reads as zero through BAout but not Rout.
        strobe(32'h1234);
        idle(); f.InPortout = 1; f.Rin = 1; tick();
        strobe(32'h0007_FFFF);
        idle(); f.InPortout = 1; f.IRin = 1; tick();
        idle(); f.Grb = 1; f.BAout = 1; f.Yin = 1; tick();
        idle(); f.ADD = 1; f.Zlowin = 1; tick();
        idle(); f.Zlowout = 1; obs("ba_y0", 32'h0);
        idle(); f.Grb = 1; f.BAout = 1; obs("ba_r0", 32'h0);
        idle(); f.Grb = 1; f.Rout = 1; obs("rout_r0", 32'h1234);
        idle(); f.Csignout = 1; obs("csign_neg", 32'hFFFF_FFFF);
        idle(); f.Csignout = 1; f.CONin = 1; tick();
        chk("con_eq_f", {31'd0, dut.con}, 32'h0);
        idle(); f.CONin = 1; tick();
        chk("con_eq_t", {31'd0, dut.con}, 32'h1);
        idle(); f.Csignout = 1; f.CONin = 1; tick();
        idle(); f.Csignout = 1; f.CONin = 1; f.CONFF = 1; tick();
        chk("conff_win", {31'd0, dut.con}, 32'h1);

        // Wrap-around with carry out.
        idle(); f.Csignout = 1; f.Yin = 1; tick();
        strobe(32'h1);
        idle(); f.InPortout = 1; f.ADD = 1; f.Zlowin = 1;
        f.Zhighin = 1; tick();
        idle(); f.Zlowout = 1; obs("wrap_zlow", 32'h0);
        idle(); f.Zhighout = 1; obs("wrap_zhigh", 32'h1);

        // Input device to output port.
        strobe(32'hA5);
        idle(); f.InPortout = 1; f.Out_Portin = 1; tick();
        chk("io_a5", f.OUTPUT_UNIT, 32'hA5);
        idle(); f.INPUT_UNIT = 32'h77; f.Strobe = 1;
        f.InPortout = 1; obs("old_on_bus", 32'hA5);
        idle(); f.InPortout = 1; obs("inport_new", 32'h77);

        // MAR clear priority and memory read/write corner cases.
        idle(); f.InPortout = 1; f.MARin = 1; f.MAR_clear = 1; tick();
        idle(); f.MARout = 1; obs("mar_clr_win", 32'h0);
        strobe(32'hCAFE);
        idle(); f.InPortout = 1; f.MDRin = 1; tick();
        idle(); f.Read = 1; f.Write = 1; f.MDRin = 1;
        f.MD_read = 1; tick();
        idle(); f.MDRout = 1; obs("rw_old", 32'h0090_0055);
        idle(); f.Read = 1; f.MDRin = 1; f.MD_read = 1; tick();
        idle(); f.MDRout = 1; obs("rw_new", 32'hCAFE);
        strobe(32'h1111);
        idle(); f.InPortout = 1; f.MDRin = 1; f.MD_read = 1; tick();
        idle(); f.MDRout = 1; obs("mdr_hold", 32'hCAFE);

        // Bus priority and the undriven bus.
        idle(); f.PCout = 1; f.MDRout = 1; obs("prio_pc", 32'h1);
        idle(); f.Rout = 1; f.PCout = 1; obs("prio_r", 32'h1234);
        idle(); f.Cin = 1; obs("bus_idle", 32'h0);

        live = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
